// File: rtl/difftest_commit_queue.sv
// Commit replay queue for the Dromajo co-sim checker. It takes up to RETIRE_WIDTH commits per
// cycle plus an optional trap, and drains them one entry per cycle in program order.
module difftest_commit_queue #(
  parameter int RETIRE_WIDTH = 2,
  parameter int DEPTH        = 16,
  parameter int XLEN         = 64,
  parameter int INST_BITS    = 32,
  parameter int HARTID_LEN   = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [HARTID_LEN-1:0]             hartid_i,
  input  logic [RETIRE_WIDTH-1:0]           rt_valid,
  input  logic [XLEN*RETIRE_WIDTH-1:0]      rt_pc,
  input  logic [INST_BITS*RETIRE_WIDTH-1:0] rt_inst,
  input  logic [XLEN*RETIRE_WIDTH-1:0]      rt_wdata,
  input  logic [XLEN*RETIRE_WIDTH-1:0]      rt_mstatus,
  input  logic [RETIRE_WIDTH-1:0]           rt_check,
  input  logic                              rt_int_xcpt,
  input  logic [XLEN-1:0]                   rt_cause,
  output logic                              valid,
  output logic [HARTID_LEN-1:0]             hartid,
  output logic [XLEN-1:0]                   pc,
  output logic [INST_BITS-1:0]              inst,
  output logic [XLEN-1:0]                   wdata,
  output logic [XLEN-1:0]                   mstatus,
  output logic                              check,
  output logic                              int_xcpt,
  output logic [XLEN-1:0]                   cause,
  output logic                              stall_core,
  output logic                              overflow,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int OCC_W    = $clog2(DEPTH+1);
  localparam int STALL_TH = DEPTH - 2*(RETIRE_WIDTH+1);

  // A trap entry stores its cause in the wdata slot.
  logic                 mem_trap    [DEPTH];
  logic [XLEN-1:0]      mem_pc      [DEPTH];
  logic [INST_BITS-1:0] mem_inst    [DEPTH];
  logic [XLEN-1:0]      mem_wdata   [DEPTH];
  logic [XLEN-1:0]      mem_mstatus [DEPTH];
  logic                 mem_check   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] slot_idx [RETIRE_WIDTH];
  logic [PTR_W-1:0] trap_idx;
  logic [OCC_W-1:0] n_in, free_slots, occ_next;
  logic             pop, accept;

  always_comb begin
    n_in = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      slot_idx[i] = wr_ptr + PTR_W'(n_in);
      if (rt_valid[i]) n_in = n_in + OCC_W'(1);
    end
    trap_idx = wr_ptr + PTR_W'(n_in);
    if (rt_int_xcpt) n_in = n_in + OCC_W'(1);
  end

  // The pop frees its slot in the same edge, so it counts toward free space.
  assign pop        = (occupancy != '0);
  assign free_slots = OCC_W'(DEPTH) - occupancy + OCC_W'(pop);
  assign accept     = (n_in <= free_slots);
  assign occ_next   = occupancy + (accept ? n_in : '0) - OCC_W'(pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      overflow   <= 1'b0;
      stall_core <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      occupancy <= occ_next;
      if (accept) wr_ptr   <= wr_ptr + PTR_W'(n_in);
      else        overflow <= 1'b1;
      stall_core <= (occ_next > OCC_W'(STALL_TH));
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (rt_valid[i]) begin
          mem_trap[slot_idx[i]]    <= 1'b0;
          mem_pc[slot_idx[i]]      <= rt_pc[i*XLEN +: XLEN];
          mem_inst[slot_idx[i]]    <= rt_inst[i*INST_BITS +: INST_BITS];
          mem_wdata[slot_idx[i]]   <= rt_wdata[i*XLEN +: XLEN];
          mem_mstatus[slot_idx[i]] <= rt_mstatus[i*XLEN +: XLEN];
          mem_check[slot_idx[i]]   <= rt_check[i];
        end
      end
      if (rt_int_xcpt) begin
        mem_trap[trap_idx]    <= 1'b1;
        mem_pc[trap_idx]      <= '0;
        mem_inst[trap_idx]    <= '0;
        mem_wdata[trap_idx]   <= rt_cause;
        mem_mstatus[trap_idx] <= '0;
        mem_check[trap_idx]   <= 1'b0;
      end
    end
  end

  assign hartid = hartid_i;

  always_comb begin
    valid    = 1'b0;
    int_xcpt = 1'b0;
    pc       = '0;
    inst     = '0;
    wdata    = '0;
    mstatus  = '0;
    check    = 1'b0;
    cause    = '0;
    if (pop) begin
      if (mem_trap[rd_ptr]) begin
        int_xcpt = 1'b1;
        cause    = mem_wdata[rd_ptr];
      end else begin
        valid   = 1'b1;
        pc      = mem_pc[rd_ptr];
        inst    = mem_inst[rd_ptr];
        wdata   = mem_wdata[rd_ptr];
        mstatus = mem_mstatus[rd_ptr];
        check   = mem_check[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue: table vectors for basic replay, plus overflow,
// mid-stream reset and pointer-wrap sequences.
module tb_difftest_commit_queue;

  logic         clock = 1'b0;
  logic         reset;
  logic [0:0]   hartid_i;
  logic [1:0]   rt_valid;
  logic [127:0] rt_pc, rt_wdata, rt_mstatus;
  logic [63:0]  rt_inst;
  logic [1:0]   rt_check;
  logic         rt_int_xcpt;
  logic [63:0]  rt_cause;
  logic         valid, check, int_xcpt, stall_core, overflow;
  logic [0:0]   hartid;
  logic [63:0]  pc, wdata, mstatus, cause;
  logic [31:0]  inst;
  logic [4:0]   occupancy;

  int checks = 0;
  int errors = 0;

  difftest_commit_queue dut (
    .clock(clock), .reset(reset), .hartid_i(hartid_i),
    .rt_valid(rt_valid), .rt_pc(rt_pc), .rt_inst(rt_inst), .rt_wdata(rt_wdata),
    .rt_mstatus(rt_mstatus), .rt_check(rt_check), .rt_int_xcpt(rt_int_xcpt), .rt_cause(rt_cause),
    .valid(valid), .hartid(hartid), .pc(pc), .inst(inst), .wdata(wdata), .mstatus(mstatus),
    .check(check), .int_xcpt(int_xcpt), .cause(cause), .stall_core(stall_core),
    .overflow(overflow), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] p0, p1;
    logic        ix;
    logic [63:0] c;
    logic        e_valid, e_int;
    logic [63:0] e_pc, e_cause;
    logic        e_check;
    int          e_occ;
  } vec_t;

  vec_t vecs [14];
  logic [63:0] seen [$];
  logic [63:0] want [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] p);
    return p[31:0] ^ 32'h13;
  endfunction

  function automatic logic [63:0] mst_of(input logic [63:0] p);
    return p ^ 64'h7e;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic ix, input logic [63:0] c);
    rt_valid    = v;
    rt_pc       = {p1, p0};
    rt_inst     = {inst_of(p1), inst_of(p0)};
    rt_wdata    = {~p1, ~p0};
    rt_mstatus  = {mst_of(p1), mst_of(p0)};
    rt_check    = 2'b01;
    rt_int_xcpt = ix;
    rt_cause    = c;
  endtask

  task automatic idle();
    drive(2'b00, 64'h0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic record();
    if (valid) seen.push_back(pc);
    else if (int_xcpt) seen.push_back({1'b1, cause[62:0]});
  endtask

  initial begin
    vecs[0]  = '{2'b11, 64'h8000_0000, 64'h8000_0004, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0000, 64'h0, 1'b1, 2};
    vecs[1]  = '{2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0004, 64'h0, 1'b0, 1};
    vecs[2]  = '{2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 0};
    vecs[3]  = '{2'b10, 64'hdead, 64'h1004, 1'b0, 64'h0, 1'b1, 1'b0, 64'h1004, 64'h0, 1'b0, 1};
    vecs[4]  = '{2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 0};
    vecs[5]  = '{2'b11, 64'h3000, 64'h3004, 1'b1, 64'h8000_0000_0000_0007, 1'b1, 1'b0, 64'h3000, 64'h0, 1'b1, 3};
    vecs[6]  = '{2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h3004, 64'h0, 1'b0, 2};
    vecs[7]  = '{2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h8000_0000_0000_0007, 1'b0, 1};
    vecs[8]  = '{2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 0};
    vecs[9]  = '{2'b01, 64'h4000, 64'hbeef, 1'b1, 64'h5, 1'b1, 1'b0, 64'h4000, 64'h0, 1'b1, 2};
    vecs[10] = '{2'b11, 64'h5000, 64'h5004, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h5, 1'b0, 3};
    vecs[11] = '{2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h5000, 64'h0, 1'b1, 2};
    vecs[12] = '{2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h5004, 64'h0, 1'b0, 1};
    vecs[13] = '{2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 0};

    reset    = 1'b0;
    hartid_i = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_int", 64'(int_xcpt), 64'd0);
    chk("rst_stall", 64'(stall_core), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("hartid", 64'(hartid), 64'd1);
    @(negedge clock);
    reset = 1'b1;

    // Basic replay, hole skipping, trap ordering
    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].v, vecs[k].p0, vecs[k].p1, vecs[k].ix, vecs[k].c);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_valid", k), 64'(valid), 64'(vecs[k].e_valid));
      chk($sformatf("v%0d_int", k), 64'(int_xcpt), 64'(vecs[k].e_int));
      chk($sformatf("v%0d_pc", k), pc, vecs[k].e_pc);
      chk($sformatf("v%0d_cause", k), cause, vecs[k].e_cause);
      chk($sformatf("v%0d_check", k), 64'(check), 64'(vecs[k].e_check));
      chk($sformatf("v%0d_occ", k), 64'(occupancy), 64'(vecs[k].e_occ));
      if (vecs[k].e_valid) begin
        chk($sformatf("v%0d_inst", k), 64'(inst), 64'(inst_of(vecs[k].e_pc)));
        chk($sformatf("v%0d_wdata", k), wdata, ~vecs[k].e_pc);
        chk($sformatf("v%0d_mstatus", k), mstatus, mst_of(vecs[k].e_pc));
      end
      chk($sformatf("v%0d_ovf", k), 64'(overflow), 64'd0);
    end

    // Overflow: 3 entries per cycle ignoring stall_core; the 8th cycle is dropped whole
    begin
      int exp_occ [8] = '{3, 5, 7, 9, 11, 13, 15, 14};
      logic exp_st [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
      logic exp_ov [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
      seen.delete();
      want.delete();
      for (int c = 0; c < 8; c++) begin
        drive(2'b11, 64'h6000 + 64'(8*c), 64'h6004 + 64'(8*c), 1'b1, 64'(c));
        if (c < 7) begin
          want.push_back(64'h6000 + 64'(8*c));
          want.push_back(64'h6004 + 64'(8*c));
          want.push_back({1'b1, 63'(c)});
        end
        @(posedge clock);
        #1;
        chk($sformatf("ovf_occ%0d", c), 64'(occupancy), 64'(exp_occ[c]));
        chk($sformatf("ovf_stall%0d", c), 64'(stall_core), 64'(exp_st[c]));
        chk($sformatf("ovf_flag%0d", c), 64'(overflow), 64'(exp_ov[c]));
        record();
      end
      idle();
      for (int n = 0; n < 40 && occupancy != 0; n++) begin
        @(posedge clock);
        #1;
        record();
      end
      chk("ovf_drained", 64'(occupancy), 64'd0);
      chk("ovf_count", 64'(seen.size()), 64'(want.size()));
      for (int i = 0; i < want.size() && i < seen.size(); i++)
        chk($sformatf("ovf_order%0d", i), seen[i], want[i]);
      chk("ovf_sticky", 64'(overflow), 64'd1);
    end

    // Async reset mid-stream
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 64'h7000, 64'h7004, 1'b1, 64'h9);
      @(posedge clock);
      #1;
    end
    chk("pre_rst_occ", 64'(occupancy), 64'd9);
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_int", 64'(int_xcpt), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    chk("mid_rst_stall", 64'(stall_core), 64'd0);
    chk("mid_rst_pc", pc, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    drive(2'b01, 64'h2000, 64'h0, 1'b0, 64'h0);
    @(posedge clock);
    #1;
    chk("post_rst_valid", 64'(valid), 64'd1);
    chk("post_rst_pc", pc, 64'h2000);
    chk("post_rst_occ", 64'(occupancy), 64'd1);
    idle();
    @(posedge clock);
    #1;
    chk("post_rst_empty", 64'(occupancy), 64'd0);

    // Pointer wrap: 40 single-lane commits, alternating lanes
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) drive(2'b01, 64'h100 + 64'(4*i), 64'h0, 1'b0, 64'h0);
      else            drive(2'b10, 64'h0, 64'h100 + 64'(4*i), 1'b0, 64'h0);
      @(posedge clock);
      #1;
      chk($sformatf("wrap_valid%0d", i), 64'(valid), 64'd1);
      chk($sformatf("wrap_pc%0d", i), pc, 64'h100 + 64'(4*i));
    end
    idle();
    @(posedge clock);
    #1;
    chk("wrap_empty", 64'(occupancy), 64'd0);
    chk("wrap_ovf", 64'(overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
